pll_ce_synth: RTL
=================

Name: pll_ce_synth

Overview:
- Parametrised, multi-channel, fully synchronous clock-enable synthesizer; successor to the fixed two-output PLL wrapper.
- Derives NUM_CH fractional-rate clock enables and 50%-duty square outputs from one reference clock, using per-channel phase accumulators (DDS style).
- Asserts locked after a programmable settle time.
- Rates are runtime-reprogrammable; each reprogram drops lock, phase-aligns all channels and re-settles.
- Feeds core/peripheral logic that must not use extra physical PLLs.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- ACC_W, 32, phase accumulator width in bits.
- LOCK_CYCLES, 1024, settle cycles before locked asserts (>=1).
- INC_INIT, {NUM_CH{32'h33333334}}, packed per-channel reset increments (ch0 in LSBs).

Ports:
- refclk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for one channel's increment.
- cfg_ch  in  3  target channel index.
- cfg_inc  in  ACC_W  new increment; f_out = f_ref * inc / 2^ACC_W.
- ce_out  out  NUM_CH  one-cycle enable pulse per channel.
- clk_out  out  NUM_CH  square wave per channel (accumulator MSB, gated).
- locked  out  1  high when all outputs are valid.

Behaviour:
- Reset (rst=1 at an edge):
  - inc[i] := INC_INIT[i]; acc[i] := 0; settle counter := 0; state := SETTLE.
  - Outputs: ce_out=0, clk_out=0, locked=0.
  - rst has priority over cfg_we in the same cycle.
- FSM:
  - SETTLE: counter increments each cycle. When counter == LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: stays in LOCKED until a valid cfg write or rst.
- Lock timing: locked=1 is registered at the LOCK_CYCLES-th rising edge after the first edge that samples rst=0.
- Accumulators:
  - Every cycle in both states: {carry, acc[i]} := acc[i] + inc[i], width ACC_W+1, wrap modulo 2^ACC_W.
- Outputs in LOCKED (registered, 1-cycle latency):
  - ce_out[i] = carry.
  - clk_out[i] = acc[i][ACC_W-1].
- Outputs in SETTLE: ce_out and clk_out are forced to 0.
- Valid cfg write (cfg_we=1, cfg_ch < NUM_CH), at that edge:
  - inc[cfg_ch] := cfg_inc.
  - All acc := 0, so channels are phase-aligned.
  - Settle counter := 0; state := SETTLE.
  - locked is 0 from the next cycle.
  - Applies equally when the write lands mid-SETTLE (counter restarts).
- Invalid cfg write (cfg_ch >= NUM_CH): ignored, no state change.
- inc = 0: channel is stopped; ce_out=0 and clk_out=0 permanently.
- inc = 2^(ACC_W-1): ce_out toggles every cycle pattern 0,1,0,1; clk_out has period 2.
- The sum in each cycle carries at most once, so there is no ce loss.

Optional Feature:
- Macro: PLL_CE_PHASE_EN.
- Defined:
  - Adds input cfg_phase [ACC_W-1:0] and a per-channel phase register ph[i] (reset value 0).
  - A valid cfg write also sets ph[cfg_ch] := cfg_phase.
  - On the alignment event (reset or any valid write), acc[i] := ph[i] instead of 0. This gives a programmable phase shift: shift = ph/2^ACC_W of the output period.
- Undefined: no port and no registers; accumulators align to 0.

Decomposition:
- Package pll_ce_pkg holds:
  - State enum {SETTLE, LOCKED}.
  - Constant MAX_CH=8.
  - Width of cfg_ch (3).
  - Helper function computing the settle-counter width, clog2(LOCK_CYCLES).
- Sub-module pll_ce_chan: one accumulator, inc/phase registers, carry/MSB output registers and gating.
  - Instantiated NUM_CH times by generate.
  - The top-level block holds the FSM, settle counter and cfg decode.

Test Plan:
- Lock timing. NUM_CH=2, LOCK_CYCLES=16: release rst → locked rises exactly at edge 16; ce_out/clk_out stay 0 before that.
- Default rate. After lock, count ch0 ce_out over 1000 cycles with inc=0x33333334 → exactly 200 pulses, spaced 5 cycles apart.
- Reprogram. Write ch1 inc=0x80000000 while LOCKED:
  - locked=0 on the next cycle, then 16 cycles of zero outputs.
  - After relock, ch1 ce_out alternates 0,1,0,1 and ch0 and ch1 both restart from acc=0.
- Edge cases:
  - cfg_ch=5 with NUM_CH=2 → no change, locked stays 1.
  - inc=0 on ch0 → zero ce_out pulses over 500 cycles.
- Reset priority. rst=1 and cfg_we=1 in the same cycle, then a mid-SETTLE write at counter=10:
  - inc returns to INC_INIT.
  - The mid-SETTLE write restarts the counter, so locked rises 16 cycles after that write.
- PLL_CE_PHASE_EN. With inc=0x40000000 and ch1 phase=0x80000000: ch1 clk_out leads ch0 by 2 cycles (half a period).

Source files
------------

// File: rtl/pll_ce_pkg.sv
// -----------------------------------------------------------------------------
// pll_ce_pkg
// Shared definitions for the pll_ce_synth clock-enable synthesizer:
//   - pll_state_t : lock FSM encoding (SETTLE / LOCKED)
//   - MAX_CH      : largest supported channel count
//   - CH_W        : width of the cfg_ch channel-select field
//   - cnt_width() : settle-counter width for a given LOCK_CYCLES
// -----------------------------------------------------------------------------
package pll_ce_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } pll_state_t;

  // cfg_ch is 3 bits wide, so eight channels is the addressable ceiling.
  localparam int MAX_CH = 8;
  localparam int CH_W   = 3;

  // The settle counter runs 0 .. LOCK_CYCLES-1, so clog2(LOCK_CYCLES) bits
  // hold it. LOCK_CYCLES = 1 would give zero bits; keep at least one.
  function automatic int cnt_width(input int lock_cycles);
    int w;
    w = $clog2(lock_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : pll_ce_pkg

// File: rtl/pll_ce_chan.sv
// -----------------------------------------------------------------------------
// pll_ce_chan
// One DDS channel of the clock-enable synthesizer: increment register,
// phase accumulator, optional phase-offset register and the registered,
// lock-gated enable / square-wave outputs.
//
// Optional feature (macro PLL_CE_PHASE_EN):
//   defined   : adds wr_phase and a phase register; alignment loads the
//               accumulator with the channel's phase instead of zero.
//   undefined : no phase port/register; alignment clears the accumulator.
//
// Ports:
//   clk       in   reference clock, rising edge
//   srst      in   synchronous active-high reset (highest priority)
//   align     in   alignment event (valid cfg write to any channel)
//   wr        in   this channel is the target of the valid cfg write
//   wr_inc    in   new increment for this channel
//   wr_phase  in   new phase offset (PLL_CE_PHASE_EN only)
//   out_en    in   outputs allowed in the coming cycle (FSM entering/in LOCKED)
//   ce_out    out  one-cycle pulse on accumulator carry
//   clk_out   out  accumulator MSB (50% duty square wave)
// -----------------------------------------------------------------------------
module pll_ce_chan
  import pll_ce_pkg::*;
#(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             align,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
`ifdef PLL_CE_PHASE_EN
  input  logic [ACC_W-1:0] wr_phase,
`endif
  input  logic             out_en,
  output logic             ce_out,
  output logic             clk_out
);

  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] align_val;
  logic [ACC_W:0]   sum;
  logic             ce_reg;
  logic             msb_reg;

  // One extra bit catches the carry. Since inc < 2^ACC_W the sum can cross
  // the wrap point at most once per cycle, so a single carry bit never
  // loses an enable.
  assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};

`ifdef PLL_CE_PHASE_EN
  logic [ACC_W-1:0] ph_reg;

  // The channel being written aligns to its freshly written phase; every
  // other channel aligns to the phase it already holds.
  assign align_val = wr ? wr_phase : ph_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      ph_reg <= '0;
    end else if (wr) begin
      ph_reg <= wr_phase;
    end
  end
`else
  assign align_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      inc_reg <= INC_RST;
      acc_reg <= '0;
      ce_reg  <= 1'b0;
      msb_reg <= 1'b0;
    end else begin
      if (wr) begin
        inc_reg <= wr_inc;
      end

      if (align) begin
        acc_reg <= align_val;
      end else begin
        acc_reg <= sum[ACC_W-1:0];
      end

      // Outputs reflect the accumulator value being loaded this edge, so
      // clk_out always equals the MSB of the live accumulator. out_en is
      // low whenever align is high, so the alignment edge never leaks a pulse.
      ce_reg  <= out_en & sum[ACC_W];
      msb_reg <= out_en & sum[ACC_W-1];
    end
  end

  assign ce_out  = ce_reg;
  assign clk_out = msb_reg;

endmodule : pll_ce_chan

// File: rtl/pll_ce_synth.sv
// -----------------------------------------------------------------------------
// pll_ce_synth
// Multi-channel, fully synchronous clock-enable synthesizer. Each channel is
// a DDS phase accumulator producing a fractional-rate enable pulse and a
// 50%-duty square wave: f_out = f_ref * inc / 2^ACC_W. A settle counter
// holds the outputs at zero for LOCK_CYCLES cycles after reset or after any
// valid reprogram, then asserts locked.
//
// Optional feature (macro PLL_CE_PHASE_EN):
//   defined   : adds cfg_phase; a valid write also stores the channel's phase
//               offset and alignment loads each accumulator with its phase.
//   undefined : no cfg_phase port; all accumulators align to zero.
//
// Parameters:
//   NUM_CH       number of channels (1..MAX_CH)
//   ACC_W        accumulator width
//   LOCK_CYCLES  settle cycles before locked (>= 1)
//   INC_INIT     packed reset increments, channel 0 in the LSBs
//
// Ports:
//   refclk     in   sole clock, rising edge
//   rst        in   synchronous active-high reset (beats cfg_we)
//   cfg_we     in   write strobe for one channel's increment
//   cfg_ch     in   target channel; writes to cfg_ch >= NUM_CH are ignored
//   cfg_inc    in   new increment
//   cfg_phase  in   new phase offset (PLL_CE_PHASE_EN only)
//   ce_out     out  per-channel one-cycle enable pulses
//   clk_out    out  per-channel square waves
//   locked     out  high when all outputs are valid
// -----------------------------------------------------------------------------
module pll_ce_synth
  import pll_ce_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {NUM_CH{32'h33333334}}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
`ifdef PLL_CE_PHASE_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int              CNT_W    = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  pll_state_t       state_reg;
  pll_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             cfg_valid;
  logic             out_en;

  // Writes to channels that do not exist are dropped entirely: no realign,
  // no loss of lock.
  assign cfg_valid = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);

  // ---------------------------------------------------------------------------
  // Lock FSM: state and settle counter register
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= SETTLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM: next state. A valid write restarts settling from any state,
  // including part-way through an earlier settle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (cfg_valid) begin
      state_next = SETTLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        SETTLE: begin
          if (cnt_reg == CNT_LAST) begin
            state_next = LOCKED;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        LOCKED: begin
          state_next = LOCKED;
        end
        default: begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Channel outputs are registered at the same edge as the FSM, so gating
  // them with the next state keeps them aligned with locked.
  assign out_en = (state_next == LOCKED);
  assign locked = (state_reg == LOCKED);

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic ch_wr;

      assign ch_wr = cfg_valid && (cfg_ch == CH_W'(gi));

      pll_ce_chan #(
        .ACC_W   (ACC_W),
        .INC_RST (INC_INIT[gi*ACC_W +: ACC_W])
      ) u_chan (
        .clk      (refclk),
        .srst     (rst),
        .align    (cfg_valid),
        .wr       (ch_wr),
        .wr_inc   (cfg_inc),
`ifdef PLL_CE_PHASE_EN
        .wr_phase (cfg_phase),
`endif
        .out_en   (out_en),
        .ce_out   (ce_out[gi]),
        .clk_out  (clk_out[gi])
      );
    end
  endgenerate

endmodule : pll_ce_synth
